// File: rtl/snurisc_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes it
// into instruction memory word by word and releases the core once the image verifies.
module snurisc_boot_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_reset,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_e;

  // Largest legal word count is the full memory depth (ADDR_W <= 16 assumed).
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic                armed_q;
  logic [7:0]          cnt_lo_q, cnt_lo_d;
  logic [15:0]         words_left_q, words_left_d;
  logic [1:0]          lane_q, lane_d;
  logic [7:0]          xor_q, xor_d;
  logic [23:0]         word_q, word_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                core_reset_q, core_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                rx_fire;
  logic [15:0]         hdr_n;

  // armed_q keeps ready low during reset while state still reads HDR0.
  assign o_rx_ready   = armed_q && (state_q inside {HDR0, HDR1, DATA, CSUM});
  assign rx_fire      = i_rx_valid && o_rx_ready;
  assign hdr_n        = {i_rx_data, cnt_lo_q};

  assign o_imem_we    = we_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_core_reset = core_reset_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= HDR0;
      armed_q      <= 1'b0;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      lane_q       <= '0;
      xor_q        <= '0;
      word_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= 1'b1;
      cnt_lo_q     <= cnt_lo_d;
      words_left_q <= words_left_d;
      lane_q       <= lane_d;
      xor_q        <= xor_d;
      word_q       <= word_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_lo_d     = cnt_lo_q;
    words_left_d = words_left_q;
    lane_d       = lane_q;
    xor_d        = xor_q;
    word_d       = word_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_reset_d = core_reset_q;
    done_d       = done_q;
    error_d      = error_q;

    // Address advances after each strobe except the last, so it never wraps.
    if (we_q && (state_q == DATA)) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (rx_fire) begin
      case (state_q)
        HDR0: begin
          cnt_lo_d = i_rx_data;
          state_d  = HDR1;
        end
        HDR1: begin
          words_left_d = hdr_n;
          lane_d       = '0;
          xor_d        = '0;
          if (hdr_n == 16'd0) begin
            state_d = CSUM;
          end else if ({1'b0, hdr_n} > MAX_WORDS) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          xor_d  = xor_q ^ i_rx_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_d[7:0]   = i_rx_data;
            2'd1: word_d[15:8]  = i_rx_data;
            2'd2: word_d[23:16] = i_rx_data;
            default: begin
              we_d         = 1'b1;
              wdata_d      = {i_rx_data, word_q};
              words_left_d = words_left_q - 16'd1;
              if (words_left_q == 16'd1) begin
                state_d = CSUM;
              end
            end
          endcase
        end
        CSUM: begin
          if (i_rx_data == xor_q) begin
            state_d      = RUN;
            core_reset_d = 1'b0;
            done_d       = 1'b1;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snurisc_boot_loader.sv
// Self-checking bench for snurisc_boot_loader: expected memory writes are queued
// as streams are built and checked by a write monitor as the strobes appear.
module tb_snurisc_boot_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [7:0]          stim_q[$];
  logic [ADDR_W+31:0]  exp_q[$];

  snurisc_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .o_rx_ready   (rx_ready),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_core_reset (core_reset),
    .o_done       (done),
    .o_error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write",
                 imem_addr, imem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_fail++;
          $display("FAIL imem_write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   imem_addr, imem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic apply_reset();
    rx_valid = 1'b0;
    rx_data  = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned waited;
    waited = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      waited++;
      if (waited > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles, required 1");
        return;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int unsigned first, input int unsigned count,
                             input int unsigned gap, input bit rnd);
    for (int unsigned i = first; i < first + count; i++) begin
      send_byte(stim_q[i]);
      repeat (rnd ? $urandom_range(gap, 0) : gap) @(posedge clk);
    end
  endtask

  task automatic load_spec_stream();
    stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
  endtask

  task automatic build_model_stream(input int unsigned n);
    logic [7:0]  x;
    logic [31:0] w;
    stim_q.delete();
    x = '0;
    stim_q.push_back(n[7:0]);
    stim_q.push_back(n[15:8]);
    for (int unsigned i = 0; i < n; i++) begin
      w = $urandom;
      exp_q.push_back({i[ADDR_W-1:0], w});
      for (int unsigned b = 0; b < 4; b++) begin
        stim_q.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    stim_q.push_back(x);
  endtask

  task automatic test_reset();
    rx_valid = 1'b0;
    rx_data  = '0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error} !==
        {1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0d wd=%08h crst=%b done=%b err=%b, required 0 0 0 00000000 1 0 0",
               rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b, required 0", rx_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_first_edge: got %b, required 1", rx_ready);
    end
  endtask

  task automatic check_run(input string name);
    n_checks++;
    if ({core_reset, done, error, rx_ready} !== 4'b0100) begin
      n_fail++;
      $display("FAIL %s_run: got crst=%b done=%b err=%b rdy=%b, required 0 1 0 0",
               name, core_reset, done, error, rx_ready);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes: got %0d writes outstanding, required 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_err(input string name);
    n_checks++;
    if ({core_reset, done, error, rx_ready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL %s_err: got crst=%b done=%b err=%b rdy=%b, required 1 0 1 0",
               name, core_reset, done, error, rx_ready);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    load_spec_stream();
    exp_q.push_back({10'd0, 32'h0000_0013});
    exp_q.push_back({10'd1, 32'h0000_006F});
    send_stream(0, 10, 0, 1'b0);
    n_checks++;
    if ({core_reset, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_before_csum: got crst=%b done=%b, required 1 0", core_reset, done);
    end
    send_stream(10, 1, 0, 1'b0);
    check_run("b2b");
  endtask

  task automatic test_gapped();
    apply_reset();
    load_spec_stream();
    exp_q.push_back({10'd0, 32'h0000_0013});
    exp_q.push_back({10'd1, 32'h0000_006F});
    send_stream(0, 11, 1, 1'b0);
    check_run("gapped");
  endtask

  task automatic test_zero_xor();
    apply_reset();
    stim_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    exp_q.push_back({10'd0, 32'hDDCC_BBAA});
    send_stream(0, 7, 0, 1'b0);
    check_run("zero_xor");
  endtask

  task automatic test_bad_csum();
    apply_reset();
    stim_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    exp_q.push_back({10'd0, 32'h0403_0201});
    send_stream(0, 7, 0, 1'b0);
    check_err("bad_csum");
    rx_valid = 1'b1;
    rx_data  = 8'h04;
    repeat (5) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check_err("bad_csum_sticky");
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bad_csum_write: got %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_oversize();
    apply_reset();
    stim_q = '{8'h01, 8'h04};
    send_stream(0, 2, 0, 1'b0);
    check_err("oversize");
    repeat (4) @(posedge clk);
    #1;
    check_err("oversize_hold");
  endtask

  task automatic test_empty();
    apply_reset();
    stim_q = '{8'h00, 8'h00, 8'h00};
    send_stream(0, 3, 0, 1'b0);
    check_run("empty");
  endtask

  task automatic test_random_gaps();
    apply_reset();
    build_model_stream(7);
    send_stream(0, stim_q.size(), 3, 1'b1);
    check_run("random_gaps");
  endtask

  task automatic test_max_words();
    apply_reset();
    build_model_stream(1 << ADDR_W);
    send_stream(0, stim_q.size(), 0, 1'b0);
    check_run("max_words");
  endtask

  task automatic test_reset_midload();
    apply_reset();
    load_spec_stream();
    send_stream(0, 5, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({core_reset, rx_ready, imem_we, done, error} !== 5'b10000) begin
      n_fail++;
      $display("FAIL midload_abort: got crst=%b rdy=%b we=%b done=%b err=%b, required 1 0 0 0 0",
               core_reset, rx_ready, imem_we, done, error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({10'd0, 32'h0000_0013});
    exp_q.push_back({10'd1, 32'h0000_006F});
    send_stream(0, 11, 0, 1'b0);
    check_run("restart");
    // Abort again after a completed word so the restart must rewind the address.
    apply_reset();
    exp_q.push_back({10'd0, 32'h0000_0013});
    send_stream(0, 7, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_addr !== '0) begin
      n_fail++;
      $display("FAIL midload_addr_clear: got %0d, required 0", imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({10'd0, 32'h0000_0013});
    exp_q.push_back({10'd1, 32'h0000_006F});
    send_stream(0, 11, 0, 1'b0);
    check_run("restart2");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_zero_xor();
    test_bad_csum();
    test_oversize();
    test_empty();
    test_random_gaps();
    test_max_words();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
